// File: rtl/posit_adder_arbiter.sv
// Round-robin front end that shares one free-running 6-stage posit adder among NREQ requesters.
// A tag pipe matched to the adder latency steers each result back and flags misaligned dones.
module posit_adder_arbiter #(
  parameter int unsigned N       = 8,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned LATENCY = 6,
  parameter int unsigned IW      = 2
) (
  input  logic              aclk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_in1,
  input  logic [NREQ*N-1:0] req_in2,
  input  logic              issue_hold,
  output logic [N-1:0]      add_in1,
  output logic [N-1:0]      add_in2,
  output logic              add_start,
  input  logic [N-1:0]      add_result,
  input  logic              add_inf,
  input  logic              add_zero,
  input  logic              add_done,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [N-1:0]      rsp_result,
  output logic              rsp_inf,
  output logic              rsp_zero,
  output logic [2:0]        inflight,
  output logic              err_unexpected,
  output logic              err_missing
);

  localparam int unsigned DW = $clog2(LATENCY + 1);

  logic [IW-1:0]                ptr_q, ptr_d, idx_q, idx_d, gnt_idx, cand, tail_idx;
  logic [DW-1:0]                drain_q, drain_d;
  logic [N-1:0]                 add_in1_q, add_in1_d, add_in2_q, add_in2_d;
  logic                         add_start_q, add_start_d;
  logic [LATENCY-1:0]           tag_vld_q, tag_vld_d;
  logic [LATENCY-1:0][IW-1:0]   tag_idx_q, tag_idx_d;
  logic [NREQ-1:0]              rsp_valid_q, rsp_valid_d;
  logic [N-1:0]                 rsp_result_q, rsp_result_d;
  logic                         rsp_inf_q, rsp_inf_d, rsp_zero_q, rsp_zero_d;
  logic [2:0]                   inflight_q, inflight_d;
  logic                         err_unexp_q, err_unexp_d, err_miss_q, err_miss_d;
  logic                         gnt_found, handshake, tail_vld;
  logic [N-1:0]                 in1_arr [NREQ];
  logic [N-1:0]                 in2_arr [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      in1_arr[i] = req_in1[i*N +: N];
      in2_arr[i] = req_in2[i*N +: N];
    end
  end

  // Search starts just after the last granted requester and wraps.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IW'((32'(ptr_q) + k) % NREQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    handshake = gnt_found & ~issue_hold & (drain_q == '0) & ~reset;
    req_ready = '0;
    if (handshake) req_ready[gnt_idx] = 1'b1;
  end

  assign tail_vld = tag_vld_q[LATENCY-1];
  assign tail_idx = tag_idx_q[LATENCY-1];

  always_comb begin
    ptr_d        = handshake ? gnt_idx : ptr_q;
    idx_d        = handshake ? gnt_idx : idx_q;
    add_in1_d    = handshake ? in1_arr[gnt_idx] : add_in1_q;
    add_in2_d    = handshake ? in2_arr[gnt_idx] : add_in2_q;
    add_start_d  = handshake;
    drain_d      = (drain_q != '0) ? drain_q - DW'(1) : drain_q;
    tag_vld_d    = {tag_vld_q[LATENCY-2:0], add_start_q};
    tag_idx_d    = {tag_idx_q[LATENCY-2:0], idx_q};
    rsp_valid_d  = '0;
    rsp_result_d = rsp_result_q;
    rsp_inf_d    = rsp_inf_q;
    rsp_zero_d   = rsp_zero_q;
    err_unexp_d  = err_unexp_q;
    err_miss_d   = err_miss_q;
    // While draining, whatever the un-resettable adder emits is stale and dropped.
    if (drain_q == '0) begin
      if (tail_vld && add_done) begin
        rsp_valid_d[tail_idx] = 1'b1;
        rsp_result_d          = add_result;
        rsp_inf_d             = add_inf;
        rsp_zero_d            = add_zero;
      end else if (tail_vld) begin
        err_miss_d = 1'b1;
      end else if (add_done) begin
        err_unexp_d = 1'b1;
      end
    end
    unique case ({add_start_q, tail_vld})
      2'b10:   inflight_d = inflight_q + 3'd1;
      2'b01:   inflight_d = inflight_q - 3'd1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      ptr_q        <= IW'(NREQ - 1);
      idx_q        <= '0;
      drain_q      <= DW'(LATENCY);
      add_in1_q    <= '0;
      add_in2_q    <= '0;
      add_start_q  <= 1'b0;
      tag_vld_q    <= '0;
      tag_idx_q    <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_inf_q    <= 1'b0;
      rsp_zero_q   <= 1'b0;
      inflight_q   <= '0;
      err_unexp_q  <= 1'b0;
      err_miss_q   <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      idx_q        <= idx_d;
      drain_q      <= drain_d;
      add_in1_q    <= add_in1_d;
      add_in2_q    <= add_in2_d;
      add_start_q  <= add_start_d;
      tag_vld_q    <= tag_vld_d;
      tag_idx_q    <= tag_idx_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_inf_q    <= rsp_inf_d;
      rsp_zero_q   <= rsp_zero_d;
      inflight_q   <= inflight_d;
      err_unexp_q  <= err_unexp_d;
      err_miss_q   <= err_miss_d;
    end
  end

  assign add_in1        = add_in1_q;
  assign add_in2        = add_in2_q;
  assign add_start      = add_start_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_result     = rsp_result_q;
  assign rsp_inf        = rsp_inf_q;
  assign rsp_zero       = rsp_zero_q;
  assign inflight       = inflight_q;
  assign err_unexpected = err_unexp_q;
  assign err_missing    = err_miss_q;

endmodule

// File: tb/tb_posit_adder_arbiter.sv
// Bench for posit_adder_arbiter: pipelined adder stub, reference arbiter and a response scoreboard.
module tb_posit_adder_arbiter;

  localparam int unsigned N    = 8;
  localparam int unsigned NREQ = 4;
  localparam int unsigned LAT  = 6;

  logic              aclk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid, req_ready, rsp_valid;
  logic [NREQ*N-1:0] req_in1, req_in2;
  logic              issue_hold, add_start, add_inf, add_zero, add_done;
  logic [N-1:0]      add_in1, add_in2, add_result, rsp_result;
  logic              rsp_inf, rsp_zero, err_unexpected, err_missing;
  logic [2:0]        inflight;

  always #5 aclk = ~aclk;

  posit_adder_arbiter #(.N(N), .NREQ(NREQ), .LATENCY(LAT), .IW(2)) dut (
    .aclk(aclk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2), .issue_hold(issue_hold),
    .add_in1(add_in1), .add_in2(add_in2), .add_start(add_start),
    .add_result(add_result), .add_inf(add_inf), .add_zero(add_zero), .add_done(add_done),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_inf(rsp_inf), .rsp_zero(rsp_zero),
    .inflight(inflight), .err_unexpected(err_unexpected), .err_missing(err_missing)
  );

  // Stand-in adder: exact for 1.0 + 1.0 in posit<8,2>, otherwise a fixed operand mix
  // so that misrouted or stale operands produce a visibly different result.
  function automatic logic [N-1:0] adder_model(input logic [N-1:0] a, input logic [N-1:0] b);
    if (a == 8'h40 && b == 8'h40) return 8'h48;
    return a ^ {b[3:0], b[7:4]};
  endfunction

  logic [LAT-1:0]        mdl_v = '0;
  logic [LAT-1:0][N-1:0] mdl_r = '0;
  int unsigned           mdl_cnt = 0;
  int unsigned           drop_seq = 32'hFFFF_FFFF;
  logic                  inj = 1'b0;

  always @(posedge aclk) begin
    mdl_v <= {mdl_v[LAT-2:0], add_start && (mdl_cnt != drop_seq)};
    mdl_r <= {mdl_r[LAT-2:0], adder_model(add_in1, add_in2)};
    if (add_start) mdl_cnt <= mdl_cnt + 1;
  end

  assign add_done   = mdl_v[LAT-1] | inj;
  assign add_result = mdl_r[LAT-1];
  assign add_inf    = (add_result == 8'h80);
  assign add_zero   = (add_result == 8'h00);

  typedef struct {
    int              due;
    logic [NREQ-1:0] onehot;
    logic [N-1:0]    res;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          ref_ptr = NREQ - 1;
  int          ref_drain = LAT;
  logic        ref_start = 1'b0;
  logic [LAT-1:0] ref_tags = '0;
  int unsigned hs_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] ref_grant(input int ptr, input logic [NREQ-1:0] v);
    logic [NREQ-1:0] g = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) begin
        g[(ptr + k) % NREQ] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  // One clock: check at the falling edge, advance the reference model at the rising edge.
  task automatic tick();
    logic [NREQ-1:0] exp_rdy;
    exp_t            e;
    int              gi;
    @(negedge aclk);
    exp_rdy = (reset || issue_hold || ref_drain != 0) ? '0 : ref_grant(ref_ptr, req_valid);
    check_eq("req_ready", req_ready, exp_rdy);
    check_eq("inflight", inflight, $countones(ref_tags));
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check_eq("rsp_valid", rsp_valid, e.onehot);
      check_eq("rsp_result", rsp_result, e.res);
      check_eq("rsp_inf", rsp_inf, e.res == 8'h80);
      check_eq("rsp_zero", rsp_zero, e.res == 8'h00);
    end else begin
      check_eq("rsp_idle", rsp_valid, '0);
    end
    @(posedge aclk);
    if (reset) begin
      ref_ptr   = NREQ - 1;
      ref_drain = LAT;
      ref_start = 1'b0;
      ref_tags  = '0;
      sb.delete();
    end else begin
      ref_tags  = {ref_tags[LAT-2:0], ref_start};
      ref_start = (exp_rdy != '0);
      if (exp_rdy != '0) begin
        gi = 0;
        for (int i = 0; i < NREQ; i++) if (exp_rdy[i]) gi = i;
        ref_ptr = gi;
        if (hs_cnt != drop_seq)
          sb.push_back('{due: cyc + LAT + 2, onehot: exp_rdy,
                         res: adder_model(req_in1[gi*N +: N], req_in2[gi*N +: N])});
        hs_cnt++;
      end
      if (ref_drain != 0) ref_drain--;
    end
    cyc++;
    #1;
  endtask

  task automatic rand_ops();
    req_in1 = $urandom;
    req_in2 = $urandom;
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; issue_hold = 1'b0; req_in1 = '0; req_in2 = '0;
    repeat (3) tick();
    check_eq("rst_rsp_valid", rsp_valid, '0);
    check_eq("rst_add_start", add_start, 1'b0);
    check_eq("rst_add_in1", add_in1, '0);
    check_eq("rst_inflight", inflight, '0);
    check_eq("rst_errs", {err_unexpected, err_missing}, 2'b00);
    reset = 1'b0;

    // Requester 1 alone, held valid through the post-reset drain window.
    req_valid = 4'b0010;
    req_in1 = 32'h0000_4000; req_in2 = 32'h0000_4000;
    repeat (LAT) tick();
    check_eq("t1_ready", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    repeat (10) tick();
    check_eq("t1_result", rsp_result, 8'h48);
    check_eq("t1_errs", {err_unexpected, err_missing}, 2'b00);

    // All requesters valid: rotating grants, pipe fills to LATENCY.
    req_valid = 4'hF;
    repeat (12) begin rand_ops(); tick(); end
    check_eq("t2_inflight_full", inflight, 3'd6);
    req_valid = '0;
    repeat (10) tick();

    // Requester 3 back-to-back, including zero and inf results.
    req_valid = 4'b1000;
    for (int i = 0; i < 10; i++) begin
      rand_ops();
      if (i == 2) begin req_in1[31:24] = 8'h00; req_in2[31:24] = 8'h00; end
      if (i == 5) begin req_in1[31:24] = 8'h80; req_in2[31:24] = 8'h00; end
      tick();
    end
    req_valid = '0;
    repeat (10) tick();

    // issue_hold freezes the pointer; release grants 0 then 2.
    req_valid = 4'b0101; issue_hold = 1'b1;
    repeat (3) tick();
    check_eq("t3_hold_ready", req_ready, '0);
    issue_hold = 1'b0;
    #1;
    check_eq("t3_first", req_ready, 4'b0001);
    tick();
    check_eq("t3_second", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    repeat (10) tick();

    // Reset with ops in flight: stale dones must be absorbed silently.
    req_valid = 4'b0001;
    repeat (3) begin rand_ops(); tick(); end
    req_valid = '0; reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    req_valid = 4'b0010; rand_ops();
    repeat (LAT) tick();
    tick();
    req_valid = '0;
    repeat (10) tick();
    check_eq("t4_errs", {err_unexpected, err_missing}, 2'b00);

    // Spurious done, then a dropped done among three ops.
    inj = 1'b1;
    tick();
    inj = 1'b0;
    tick();
    check_eq("t5_unexp", err_unexpected, 1'b1);
    check_eq("t5_miss_clear", err_missing, 1'b0);
    drop_seq = hs_cnt + 1;
    req_valid = 4'b0100;
    repeat (3) begin rand_ops(); tick(); end
    req_valid = '0;
    repeat (12) tick();
    check_eq("t5_miss", err_missing, 1'b1);
    check_eq("t5_unexp_sticky", err_unexpected, 1'b1);
    reset = 1'b1;
    tick();
    check_eq("t5_errs_reset", {err_unexpected, err_missing}, 2'b00);
    reset = 1'b0;
    repeat (LAT + 1) tick();

    check_eq("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
